// File: rtl/rk_sdspi_pkg.sv
// rk_sdspi_pkg: shared constants and types for the SD-card SPI master.
//   H_SLOW_DEF / H_FAST_DEF : default SCK half-periods in clk cycles
//   DIV_W                   : half-period counter width
//   CTRL_*                  : bit positions in the CTRL register
//   state_e                 : transfer FSM states
package rk_sdspi_pkg;
  localparam int H_SLOW_DEF = 60;  // 48 MHz / 120 = 400 kHz
  localparam int H_FAST_DEF = 3;   // 48 MHz / 6   = 8 MHz
  localparam int DIV_W      = 8;

  localparam int CTRL_CS   = 0;
  localparam int CTRL_FAST = 1;
  localparam int CTRL_BUSY = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;
endpackage

// File: rtl/rk_sdspi_if.sv
// rk_sdspi_if: CPU-side register window of the SD SPI master.
//   addr  : 0 = CTRL, 1 = DATA
//   we_n  : active-low write strobe (level, may be held)
//   idata : write data
//   odata : read data, combinational on addr
interface rk_sdspi_if;
  logic       addr;
  logic       we_n;
  logic [7:0] idata;
  logic [7:0] odata;

  modport master (output addr, we_n, idata, input odata);
  modport slave  (input addr, we_n, idata, output odata);
endinterface

// File: rtl/rk_sdspi_div.sv
// rk_sdspi_div: loadable half-period down-counter.
//   load   : force counter to reload (transfer start)
//   en     : count enable
//   reload : value taken on load and after each tick (H-1)
//   tick   : one-cycle pulse when the enabled counter reaches zero
module rk_sdspi_div
  import rk_sdspi_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] reload,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset_n)          cnt <= '0;
    else if (load || tick) cnt <= reload;
    else if (en)           cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/rk_sdspi.sv
// rk_sdspi: byte-wide SPI mode-0 master for the SD card.
//   clk, reset_n : 48 MHz clock, synchronous active-low reset
//   bus          : CPU register window (CTRL = {busy,5'b0,fast,cs}, DATA = rx)
//   sd_miso      : card DO
//   sd_cs_n, sd_mosi, sd_sck : card CS#, DI, CLK
// Build option: RK_SDSPI_FAST_EN makes the CTRL fast bit writable and selects
// H_FAST; without it the fast bit reads 0 and H is fixed at H_SLOW.
module rk_sdspi
  import rk_sdspi_pkg::*;
#(
  parameter int H_SLOW = H_SLOW_DEF,
  parameter int H_FAST = H_FAST_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  rk_sdspi_if.slave     bus,
  input  logic          sd_miso,
  output logic          sd_cs_n,
  output logic          sd_mosi,
  output logic          sd_sck
);
  state_e           state, state_nxt;
  logic             we_q, we_fall, start, ctrl_wr;
  logic             busy, div_en, tick;
  logic             cs, fast;
  logic [7:0]       shreg, rx, ctrl_rd;
  logic [2:0]       bitcnt;
  logic [DIV_W-1:0] div_reload;

  // Only the falling edge of the strobe counts, so a held-low we_n acts once.
  assign we_fall = !bus.we_n && we_q;
  assign start   = we_fall &&  bus.addr && (state == ST_IDLE);
  assign ctrl_wr = we_fall && !bus.addr && (state == ST_IDLE);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (tick && sd_sck && bitcnt == 3'd7) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy   = (state == ST_SHIFT);
    div_en = busy;
  end

`ifdef RK_SDSPI_FAST_EN
  // H is latched at start so a mode change cannot disturb a running byte.
  logic [DIV_W-1:0] h_new, h_lat;
  assign h_new      = fast ? DIV_W'(H_FAST) : DIV_W'(H_SLOW);
  assign div_reload = start ? h_new - 1'b1 : h_lat - 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fast  <= 1'b0;
      h_lat <= DIV_W'(H_SLOW);
    end else begin
      if (ctrl_wr) fast  <= bus.idata[CTRL_FAST];
      if (start)   h_lat <= h_new;
    end
  end
`else
  assign fast       = 1'b0;
  assign div_reload = DIV_W'(H_SLOW - 1);
`endif

  rk_sdspi_div u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start),
    .en      (div_en),
    .reload  (div_reload),
    .tick    (tick)
  );

  // Shifting left on the rise leaves the next outgoing bit in shreg[7],
  // ready to be driven on the following fall.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      we_q   <= 1'b1;
      cs     <= 1'b0;
      shreg  <= 8'hFF;
      rx     <= 8'hFF;
      bitcnt <= 3'd0;
      sd_sck <= 1'b0;
      sd_mosi<= 1'b1;
    end else begin
      we_q <= bus.we_n;
      if (ctrl_wr) cs <= bus.idata[CTRL_CS];
      if (start) begin
        shreg   <= bus.idata;
        sd_mosi <= bus.idata[7];
        bitcnt  <= 3'd0;
      end else if (tick) begin
        if (!sd_sck) begin
          sd_sck <= 1'b1;
          shreg  <= {shreg[6:0], sd_miso};
        end else begin
          sd_sck <= 1'b0;
          if (bitcnt == 3'd7) begin
            rx      <= shreg;
            sd_mosi <= 1'b1;
          end else begin
            bitcnt  <= bitcnt + 3'd1;
            sd_mosi <= shreg[7];
          end
        end
      end
    end
  end

  assign sd_cs_n = ~cs;

  always_comb begin
    ctrl_rd            = '0;
    ctrl_rd[CTRL_BUSY] = busy;
    ctrl_rd[CTRL_FAST] = fast;
    ctrl_rd[CTRL_CS]   = cs;
  end

  assign bus.odata = bus.addr ? rx : ctrl_rd;
endmodule

// File: tb/tb_rk_sdspi.sv
module tb_rk_sdspi;
  logic clk, reset_n, sd_miso, sd_cs_n, sd_mosi, sd_sck;
  int   checks, errors;

  rk_sdspi_if bus();

  rk_sdspi dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .sd_miso (sd_miso),
    .sd_cs_n (sd_cs_n),
    .sd_mosi (sd_mosi),
    .sd_sck  (sd_sck)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic cpu_write(input logic a, input logic [7:0] d);
    @(negedge clk); bus.addr = a; bus.idata = d; bus.we_n = 1'b0;
    @(negedge clk); bus.we_n = 1'b1; bus.addr = 1'b0;
  endtask

  // Starts a DATA write of tx and follows it to the end, acting as the card
  // (MISO returns pat MSB first, advanced on each SCK fall).
  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] pat,
                          input int hold, input int inj_at,
                          input logic inj_addr, input logic [7:0] inj_data,
                          output int busy_cyc, output int rises,
                          output logic [7:0] mosi_seen,
                          output int hi_min, output int hi_max,
                          output logic cs_glitch, output logic [7:0] rx_rd);
    int cyc, hi_run;
    logic sck_q, bsy;
    busy_cyc = 0; rises = 0; mosi_seen = 8'h00; hi_min = 9999; hi_max = 0;
    cs_glitch = 1'b0; hi_run = 0; sck_q = 1'b0; cyc = 0; bsy = 1'b1;
    sd_miso = pat[7];
    @(negedge clk); bus.addr = 1'b1; bus.idata = tx; bus.we_n = 1'b0;
    while (bsy && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == hold) begin bus.we_n = 1'b1; bus.addr = 1'b0; end
      if (cyc == inj_at) begin bus.addr = inj_addr; bus.idata = inj_data; bus.we_n = 1'b0; end
      if (cyc == inj_at + 1) begin bus.we_n = 1'b1; bus.addr = 1'b0; end
      #1;
      bsy = bus.addr ? 1'b1 : bus.odata[7];
      if (bsy) busy_cyc++;
      if (sd_cs_n) cs_glitch = 1'b1;
      if (sd_sck) hi_run++;
      if (sd_sck && !sck_q) begin
        rises++;
        mosi_seen = {mosi_seen[6:0], sd_mosi};
      end
      if (!sd_sck && sck_q) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0;
        if (rises < 8) sd_miso = pat[7 - rises];
      end
      sck_q = sd_sck;
    end
    checks++;
    if (bsy) begin
      errors++;
      $display("FAIL xfer_timeout: still busy after %0d cycles, required idle", cyc);
    end
    bus.addr = 1'b1; #1; rx_rd = bus.odata; bus.addr = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; bus.we_n = 1'b1; bus.addr = 1'b0; bus.idata = 8'h00; sd_miso = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (sd_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b exp 1", sd_cs_n); end
    checks++; if (sd_sck !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b exp 0", sd_sck); end
    checks++; if (sd_mosi !== 1'b1) begin errors++; $display("FAIL rst_mosi: got %b exp 1", sd_mosi); end
    checks++; if (bus.odata !== 8'h00) begin errors++; $display("FAIL rst_ctrl: got %h exp 00", bus.odata); end
    bus.addr = 1'b1; #1;
    checks++; if (bus.odata !== 8'hFF) begin errors++; $display("FAIL rst_data: got %h exp ff", bus.odata); end
    bus.addr = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ctrl;
    cpu_write(1'b0, 8'h01); #1;
    checks++; if (sd_cs_n !== 1'b0) begin errors++; $display("FAIL ctrl_cs_n: got %b exp 0", sd_cs_n); end
    checks++; if (bus.odata !== 8'h01) begin errors++; $display("FAIL ctrl_rd: got %h exp 01", bus.odata); end
  endtask

  task automatic test_slow_xfer;
    int bc, r, hmin, hmax; logic [7:0] ms, rx; logic g;
    run_xfer(8'hA5, 8'h3C, 1, -1, 1'b0, 8'h00, bc, r, ms, hmin, hmax, g, rx);
    checks++; if (ms !== 8'hA5) begin errors++; $display("FAIL slow_mosi: got %h exp a5", ms); end
    checks++; if (r != 8) begin errors++; $display("FAIL slow_rises: got %0d exp 8", r); end
    checks++; if (bc != 960) begin errors++; $display("FAIL slow_busy: got %0d exp 960", bc); end
    checks++; if (rx !== 8'h3C) begin errors++; $display("FAIL slow_rx: got %h exp 3c", rx); end
    checks++; if (g !== 1'b0) begin errors++; $display("FAIL slow_cs: cs_n rose during transfer"); end
  endtask

  task automatic test_held_strobe;
    int bc, r, hmin, hmax; logic [7:0] ms, rx; logic g;
    run_xfer(8'h5A, 8'h81, 200, -1, 1'b0, 8'h00, bc, r, ms, hmin, hmax, g, rx);
    checks++; if (bc != 960) begin errors++; $display("FAIL held_busy: got %0d exp 960", bc); end
    checks++; if (r != 8) begin errors++; $display("FAIL held_rises: got %0d exp 8", r); end
    checks++; if (rx !== 8'h81) begin errors++; $display("FAIL held_rx: got %h exp 81", rx); end
    repeat (50) @(negedge clk); #1;
    checks++; if (bus.odata[7] !== 1'b0 || sd_sck !== 1'b0) begin
      errors++; $display("FAIL held_retrig: busy %b sck %b exp 0 0", bus.odata[7], sd_sck);
    end
  endtask

  task automatic test_write_during_busy;
    int bc, r, hmin, hmax; logic [7:0] ms, rx; logic g;
    run_xfer(8'hC3, 8'h96, 1, 300, 1'b1, 8'h00, bc, r, ms, hmin, hmax, g, rx);
    checks++; if (ms !== 8'hC3) begin errors++; $display("FAIL busy_data_mosi: got %h exp c3", ms); end
    checks++; if (bc != 960) begin errors++; $display("FAIL busy_data_len: got %0d exp 960", bc); end
    checks++; if (rx !== 8'h96) begin errors++; $display("FAIL busy_data_rx: got %h exp 96", rx); end
    run_xfer(8'h3C, 8'h0F, 1, 300, 1'b0, 8'h00, bc, r, ms, hmin, hmax, g, rx);
    checks++; if (g !== 1'b0) begin errors++; $display("FAIL busy_ctrl_cs: cs_n rose, exp stays 0"); end
    checks++; if (rx !== 8'h0F) begin errors++; $display("FAIL busy_ctrl_rx: got %h exp 0f", rx); end
    #1;
    checks++; if (bus.odata !== 8'h01) begin errors++; $display("FAIL busy_ctrl_rd: got %h exp 01", bus.odata); end
  endtask

  task automatic test_mode;
    int bc, r, hmin, hmax; logic [7:0] ms, rx; logic g;
    cpu_write(1'b0, 8'h03); #1;
`ifdef RK_SDSPI_FAST_EN
    checks++; if (bus.odata !== 8'h03) begin errors++; $display("FAIL fast_ctrl_rd: got %h exp 03", bus.odata); end
    run_xfer(8'hFF, 8'h00, 1, -1, 1'b0, 8'h00, bc, r, ms, hmin, hmax, g, rx);
    checks++; if (bc != 48) begin errors++; $display("FAIL fast_busy: got %0d exp 48", bc); end
    checks++; if (r != 8) begin errors++; $display("FAIL fast_rises: got %0d exp 8", r); end
    checks++; if (hmin != 3 || hmax != 3) begin errors++; $display("FAIL fast_hi: got %0d..%0d exp 3..3", hmin, hmax); end
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL fast_rx: got %h exp 00", rx); end
`else
    checks++; if (bus.odata !== 8'h01) begin errors++; $display("FAIL nofast_ctrl_rd: got %h exp 01", bus.odata); end
    run_xfer(8'h66, 8'h99, 1, -1, 1'b0, 8'h00, bc, r, ms, hmin, hmax, g, rx);
    checks++; if (bc != 960) begin errors++; $display("FAIL nofast_busy: got %0d exp 960", bc); end
    checks++; if (hmin != 60 || hmax != 60) begin errors++; $display("FAIL nofast_hi: got %0d..%0d exp 60..60", hmin, hmax); end
    checks++; if (rx !== 8'h99) begin errors++; $display("FAIL nofast_rx: got %h exp 99", rx); end
`endif
  endtask

  task automatic test_reset_mid;
    int cyc, rises; logic sck_q;
    sd_miso = 1'b0;
    @(negedge clk); bus.addr = 1'b1; bus.idata = 8'h55; bus.we_n = 1'b0;
    @(negedge clk); bus.we_n = 1'b1; bus.addr = 1'b0;
    rises = 0; sck_q = 1'b0; cyc = 0;
    while (rises < 4 && cyc < 2000) begin
      @(negedge clk); cyc++;
      if (sd_sck && !sck_q) rises++;
      sck_q = sd_sck;
    end
    checks++; if (rises != 4) begin errors++; $display("FAIL rmid_reach: got %0d rises exp 4", rises); end
    reset_n = 1'b0;
    @(negedge clk); #1;
    checks++; if (sd_sck !== 1'b0) begin errors++; $display("FAIL rmid_sck: got %b exp 0", sd_sck); end
    checks++; if (sd_cs_n !== 1'b1) begin errors++; $display("FAIL rmid_cs_n: got %b exp 1", sd_cs_n); end
    checks++; if (sd_mosi !== 1'b1) begin errors++; $display("FAIL rmid_mosi: got %b exp 1", sd_mosi); end
    checks++; if (bus.odata !== 8'h00) begin errors++; $display("FAIL rmid_ctrl: got %h exp 00", bus.odata); end
    bus.addr = 1'b1; #1;
    checks++; if (bus.odata !== 8'hFF) begin errors++; $display("FAIL rmid_rx: got %h exp ff", bus.odata); end
    bus.addr = 1'b0;
    reset_n = 1'b1;
    repeat (200) @(negedge clk); #1;
    checks++; if (sd_sck !== 1'b0 || bus.odata !== 8'h00) begin
      errors++; $display("FAIL rmid_idle: sck %b ctrl %h exp 0 00", sd_sck, bus.odata);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset;
    test_ctrl;
    test_slow_xfer;
    test_held_strobe;
    test_write_during_busy;
    test_mode;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
